// File: rtl/sram_pingpong_pkg.sv
// Shared constants and types for the ping-pong staging SRAM.
package sram_pingpong_pkg;
    localparam int NUM_BANKS = 2;
    localparam int BANK_BITS = 1;

    typedef logic [BANK_BITS-1:0] bank_idx_t;

    function automatic bank_idx_t other_bank(input bank_idx_t b);
        return ~b;
    endfunction
endpackage

// File: rtl/sram_pingpong_if.sv
// Producer/consumer bus of the ping-pong SRAM; master drives strobes, slave is the SRAM.
interface sram_pingpong_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_en_n;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_done;
    logic                  wr_ready;
    logic                  rd_en_n;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_done;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [1:0]            bank_full;
    logic                  wr_err;
    logic                  rd_err;

    modport master (
        output wr_en_n, wr_addr, wr_data, wr_done, rd_en_n, rd_addr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_valid, bank_full, wr_err, rd_err
    );

    modport slave (
        input  wr_en_n, wr_addr, wr_data, wr_done, rd_en_n, rd_addr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_valid, bank_full, wr_err, rd_err
    );
endinterface

// File: rtl/sram_bank.sv
// Single-port SRAM bank: active-low chip select / write enable, registered read port.
module sram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cs_n,
    input  logic                  i_we_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (!i_cs_n && !i_we_n)
            r_mem[i_addr] <= i_wdata;
    end

    // Only the output register is reset; it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdata <= '0;
        else if (!i_cs_n && i_we_n)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sram_pingpong.sv
// Two-bank ping-pong SRAM: producer fills one bank while the consumer drains the other.
module sram_pingpong
    import sram_pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_pingpong_if.slave  bus
);
    bank_idx_t                             r_wsel;
    bank_idx_t                             r_rsel;
    bank_idx_t                             r_rd_bank;
    logic [NUM_BANKS-1:0]                  r_full;
    logic                                  r_rd_valid;
    logic                                  r_wr_err;
    logic                                  r_rd_err;

    logic                                  w_wr_ok;
    logic                                  w_rd_ok;
    logic                                  w_wr_go;
    logic                                  w_rd_go;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  w_rdata;

    assign w_wr_ok = !r_full[r_wsel];
    assign w_rd_ok = r_full[r_rsel];
    assign w_wr_go = !bus.wr_en_n && w_wr_ok;
    assign w_rd_go = !bus.rd_en_n && w_rd_ok;

    // A FREE bank only takes writes and a FULL bank only serves reads,
    // so each single-port bank sees at most one access per cycle.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_wr_hit;
        logic w_rd_hit;

        assign w_wr_hit = w_wr_go && (r_wsel == bank_idx_t'(b));
        assign w_rd_hit = w_rd_go && (r_rsel == bank_idx_t'(b));

        sram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_cs_n  (!(w_wr_hit || w_rd_hit)),
            .i_we_n  (!w_wr_hit),
            .i_addr  (w_wr_hit ? bus.wr_addr : bus.rd_addr),
            .i_wdata (bus.wr_data),
            .o_rdata (w_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel     <= '0;
            r_rsel     <= '0;
            r_rd_bank  <= '0;
            r_full     <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_go;
            if (w_rd_go)
                r_rd_bank <= r_rsel;
            if (bus.wr_done && w_wr_ok) begin
                r_full[r_wsel] <= 1'b1;
                r_wsel         <= other_bank(r_wsel);
            end
            if (bus.rd_done && w_rd_ok) begin
                r_full[r_rsel] <= 1'b0;
                r_rsel         <= other_bank(r_rsel);
            end
            if ((!bus.wr_en_n || bus.wr_done) && !w_wr_ok)
                r_wr_err <= 1'b1;
            if ((!bus.rd_en_n || bus.rd_done) && !w_rd_ok)
                r_rd_err <= 1'b1;
        end
    end

    // Bank output registers hold between reads, so the mux keeps rd_data stable.
    assign bus.rd_data   = w_rdata[r_rd_bank];
    assign bus.rd_valid  = r_rd_valid;
    assign bus.wr_ready  = w_wr_ok;
    assign bus.rd_ready  = w_rd_ok;
    assign bus.bank_full = r_full;
    assign bus.wr_err    = r_wr_err;
    assign bus.rd_err    = r_rd_err;
endmodule

// File: tb/tb_sram_pingpong.sv
// Scoreboard bench for sram_pingpong against a bank/flag reference model.
module tb_sram_pingpong;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_pingpong_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

    sram_pingpong #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct { int due; logic [15:0] data; } exp_t;
    exp_t q[$];

    logic [15:0] m_mem [2][32];
    int          m_wsel, m_rsel;
    bit          m_full [2];
    bit          m_werr, m_rerr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [15:0] last_data = '0;

    always @(posedge clk) cyc++;

    // Monitor: consumes expected read data when it falls due.
    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            last_data = '0;
        end else begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            tests++;
            if (bus.rd_valid !== exp_v) begin
                fails++;
                $display("FAIL rd_valid cyc=%0d got %0b exp %0b", cyc, bus.rd_valid, exp_v);
            end
            if (exp_v) begin
                last_data = q[0].data;
                void'(q.pop_front());
            end
            tests++;
            if (bus.rd_data !== last_data) begin
                fails++;
                $display("FAIL rd_data cyc=%0d got %04h exp %04h", cyc, bus.rd_data, last_data);
            end
        end
    end

    task automatic check_flags();
        logic [5:0] got, exp;
        got = {bus.wr_ready, bus.rd_ready, bus.bank_full, bus.wr_err, bus.rd_err};
        exp = {!m_full[m_wsel], m_full[m_rsel], m_full[1], m_full[0], m_werr, m_rerr};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL flags(wrdy,rrdy,full1,full0,werr,rerr) cyc=%0d got %06b exp %06b",
                     cyc, got, exp);
        end
    endtask

    task automatic step(input bit wen_n, input int wa, input logic [15:0] wd, input bit wdone,
                        input bit ren_n, input int ra, input bit rdone);
        bit wr_ok, rd_ok;
        exp_t e;
        @(negedge clk);
        check_flags();
        bus.wr_en_n = wen_n; bus.wr_addr = wa[4:0]; bus.wr_data = wd; bus.wr_done = wdone;
        bus.rd_en_n = ren_n; bus.rd_addr = ra[4:0]; bus.rd_done = rdone;
        wr_ok = !m_full[m_wsel];
        rd_ok = m_full[m_rsel];
        if (!ren_n) begin
            if (rd_ok) begin
                e.due = cyc + 1; e.data = m_mem[m_rsel][ra];
                q.push_back(e);
            end else m_rerr = 1;
        end
        if (rdone && !rd_ok) m_rerr = 1;
        if (!wen_n) begin
            if (wr_ok) m_mem[m_wsel][wa] = wd;
            else       m_werr = 1;
        end
        if (wdone && !wr_ok) m_werr = 1;
        if (wdone && wr_ok) begin m_full[m_wsel] = 1; m_wsel ^= 1; end
        if (rdone && rd_ok) begin m_full[m_rsel] = 0; m_rsel ^= 1; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0, 1, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_wsel = 0; m_rsel = 0; m_full[0] = 0; m_full[1] = 0; m_werr = 0; m_rerr = 0;
        bus.wr_en_n = 1; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 0;
        bus.rd_en_n = 1; bus.rd_addr = '0; bus.rd_done = 0;
        #1;
        tests++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0) begin
            fails++;
            $display("FAIL async_reset got valid=%0b data=%04h exp valid=0 data=0000",
                     bus.rd_valid, bus.rd_data);
        end
        repeat (2) @(negedge clk);
        check_flags();
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 32; i++) step(0, i, base + 16'(i), 0, 1, 0, 0);
        step(1, 0, 16'h0, 1, 1, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 32; i++) step(1, 0, 16'h0, 0, 0, i, 0);
        step(1, 0, 16'h0, 0, 1, 0, 1);
    endtask

    initial begin
        do_reset();
        idle(1);
        // Fill, drain, then concurrent ping-pong with simultaneous done pulses.
        fill(16'h1000);
        drain();
        fill(16'h2000);
        for (int i = 0; i < 32; i++) step(0, i, 16'h3000 + 16'(i), 0, 0, 31 - i, 0);
        step(1, 0, 16'h0, 1, 1, 0, 1);
        drain();
        idle(2);

        // Overflow: both banks full, dropped write and done.
        do_reset();
        fill(16'h1000);
        fill(16'h2000);
        step(0, 3, 16'hDEAD, 0, 1, 0, 0);
        step(1, 0, 16'h0, 1, 1, 0, 0);
        step(1, 0, 16'h0, 0, 0, 3, 0);
        idle(2);

        // Underflow: read and rd_done with nothing readable.
        do_reset();
        step(1, 0, 16'h0, 0, 0, 4, 1);
        idle(2);

        // Reset in the middle of a read.
        do_reset();
        fill(16'h1000);
        step(1, 0, 16'h0, 0, 0, 5, 0);
        step(1, 0, 16'h0, 0, 0, 6, 0);
        #2;
        do_reset();
        idle(2);

        // Randomized traffic, including out-of-turn strobes.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 3) == 0, $urandom_range(31), 16'($urandom), ($urandom % 14) == 0,
                 ($urandom % 3) == 0, $urandom_range(31), ($urandom % 14) == 0);
        end
        idle(3);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_reads got %0d exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_pingpong.md
# sram_pingpong

Double-buffered (ping-pong) on-chip SRAM for CNN feature-map and weight staging. Holds two banks of `2**ADDR_WIDTH` words. A producer fills one bank while a consumer drains the other, and bank ownership swaps through done-pulse handshakes. It sits between a loader/DMA stage and the convolution datapath, and supersedes the single-bank scratch SRAM for streaming layers.

## Interface
- `DATA_WIDTH`, 16, word width in bits
- `ADDR_WIDTH`, 5, word address width per bank; depth per bank = `2**ADDR_WIDTH`
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en_n`  in  1  active-low write strobe (producer side)
- `wr_addr`  in  ADDR_WIDTH  write word address within the producer's bank
- `wr_data`  in  DATA_WIDTH  write data
- `wr_done`  in  1  active-high pulse: producer has finished filling its bank
- `wr_ready`  out  1  producer's bank is free (not full)
- `rd_en_n`  in  1  active-low read strobe (consumer side)
- `rd_addr`  in  ADDR_WIDTH  read word address within the consumer's bank
- `rd_done`  in  1  active-high pulse: consumer has finished with its bank
- `rd_ready`  out  1  consumer's bank is full (readable)
- `rd_data`  out  DATA_WIDTH  registered read data
- `rd_valid`  out  1  `rd_data` is valid this cycle
- `bank_full`  out  2  per-bank full flags, bit i = bank i
- `wr_err`  out  1  sticky: a write or `wr_done` arrived while `wr_ready`=0
- `rd_err`  out  1  sticky: a read or `rd_done` arrived while `rd_ready`=0

## Operation
- State registers: `wsel` (producer bank), `rsel` (consumer bank), `full[1:0]`.
- Reset values: `wsel`=0, `rsel`=0, `full`=00, `rd_data`=0, `rd_valid`=0, `wr_err`=0, `rd_err`=0. Memory contents are not reset.
- Combinational outputs: `wr_ready` = !`full[wsel]`; `rd_ready` = `full[rsel]`; `bank_full` = `full`.
- Write: when `wr_en_n`=0 and `wr_ready`=1, `bank[wsel][wr_addr]` <= `wr_data`. When `wr_ready`=0, the write is dropped and `wr_err` is set.
- `wr_done` with `wr_ready`=1: sets `full[wsel]` and toggles `wsel`. With `wr_ready`=0: ignored, sets `wr_err`.
- Read: when `rd_en_n`=0 and `rd_ready`=1, `rd_data` <= `bank[rsel][rd_addr]` and `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `rd_data` holds its last value. A read with `rd_ready`=0 sets `rd_err`.
- `rd_done` with `rd_ready`=1: clears `full[rsel]` and toggles `rsel`. With `rd_ready`=0: ignored, sets `rd_err`.
- Per-bank states (derived from the flags, no extra encoding): FREE (`full`=0), FULL (`full`=1). FREE -> FULL on accepted `wr_done`; FULL -> FREE on accepted `rd_done`.
- Sticky errors clear only on reset.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data and `rd_valid` visible after edge N.
- Write and `wr_done` in the same cycle: the write lands in the old `wsel` bank, then `wsel` toggles.
- Read and `rd_done` in the same cycle: the read is served from the old `rsel` bank (`rd_valid`=1 next cycle), then `rsel` toggles.
- Simultaneous `wr_done` and `rd_done`: both apply in the same edge. The banks are necessarily different because one is FREE and the other FULL; if `wsel`==`rsel`, only one flag is consistent and only the qualified action applies.
- Write and read to the same bank and address in one cycle cannot occur legally, since one bank is FREE and the other FULL. If forced, the write is dropped (bank FULL) and the read returns old data.
- New flag state (`wr_ready`, `rd_ready`) is visible the cycle after the done pulse.
- Asynchronous reset mid-operation immediately forces all reset values, including `rd_valid`=0. Any in-flight read is discarded.
- Address wrap-around does not apply: addresses are exactly `ADDR_WIDTH` bits and all values are valid.

## Structure
- Shared package: constants `NUM_BANKS`=2 and `BANK_BITS`=1, plus a bank-index typedef.
- One sub-module, `sram_bank`: a single-port `2**ADDR_WIDTH` x `DATA_WIDTH` array with active-low enable/write-enable and a registered read, instantiated twice.
- The top level holds the select/flag control, the output mux/register, and the error logic.

## Test plan
- Reset then fill: after reset, check `wr_ready`=1 and `rd_ready`=0. Write 0x1000+i to addr i (i=0..31), pulse `wr_done` -> `bank_full`=01, `wsel`=1, `rd_ready`=1.
- Drain with latency: read addr 0..31 back-to-back -> `rd_data`=0x1000+i exactly one cycle after each address, `rd_valid` high for 32 cycles. Pulse `rd_done` -> `bank_full`=00.
- Concurrent ping-pong: fill bank 1 with 0x2000+i while reading bank 0. Pulse `wr_done` and `rd_done` in the same cycle -> `bank_full`=10, `wsel`=0, `rsel`=1. Verify no data corruption in either bank.
- Overflow: fill both banks without draining -> `wr_ready`=0. Write 0xDEAD to addr 3 -> write dropped, `wr_err`=1, bank 0 addr 3 still holds 0x1003.
- Underflow: after reset, assert a read and a `rd_done` -> `rd_valid` stays 0, `rd_err`=1, `full` unchanged.
- Reset mid-read: issue a read, assert `rst_n`=0 before the next edge -> `rd_valid`=0, `rd_data`=0, all flags and errors cleared.
